// File: rtl/div_ctrl.sv
// ============================================================================
// Module      : div_ctrl
// Description : Multi-cycle radix-2 restoring DIV/DIVU sequencer for EX stage.
//               Optional macro DIV_EARLY_OUT_EN: skip iterations when
//               |dividend| < |divisor|.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq,
  output logic               busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_rq;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_signed;
  logic               r_sign1;
  logic               r_sign2;

  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_next;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_fixed;

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign w_abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign w_abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // Upper WIDTH+1 bits of the left-shifted register minus the divisor
  assign w_trial = r_rq[2*WIDTH-1:WIDTH-1] - {1'b0, r_divisor};
  assign w_next  = w_trial[WIDTH] ? {r_rq[2*WIDTH-2:0], 1'b0}
                                  : {w_trial[WIDTH-1:0], r_rq[WIDTH-2:0], 1'b1};
  assign w_quo   = w_next[WIDTH-1:0];
  assign w_rem   = w_next[2*WIDTH-1:WIDTH];

  assign w_fixed = {(r_signed && r_sign1)             ? -w_rem : w_rem,
                    (r_signed && (r_sign1 ^ r_sign2)) ? -w_quo : w_quo};

  assign stallreq = start & ~ready & ~annul;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rq      <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else if (annul) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      ready   <= 1'b0;
      result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_signed  <= signed_div;
            r_sign1   <= signed_div & opdata1[WIDTH-1];
            r_sign2   <= signed_div & opdata2[WIDTH-1];
            r_divisor <= w_abs2;
            r_rq      <= {{WIDTH{1'b0}}, w_abs1};
            r_cnt     <= '0;
            if (opdata2 == '0) begin
              r_state <= S_BYZERO;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (w_abs1 < w_abs2) begin
              r_state <= S_END;
              ready   <= 1'b1;
              result  <= {opdata1, {WIDTH{1'b0}}};
            end
`endif
            else begin
              r_state <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          r_state <= S_END;
          ready   <= 1'b1;
          result  <= '0;
        end
        S_ON: begin
          r_rq  <= w_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_last) begin
            r_state <= S_END;
            ready   <= 1'b1;
            result  <= w_fixed;
          end
        end
        S_END: begin
          if (!start) begin
            r_state <= S_IDLE;
            ready   <= 1'b0;
            result  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// Module      : tb_div_ctrl
// Description : Directed scoreboard bench for div_ctrl (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           signed_div = 1'b0;
  logic [W-1:0]   opdata1 = '0;
  logic [W-1:0]   opdata2 = '0;
  logic           annul = 1'b0;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stallreq;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return 33;
`endif
    return 33;
  endfunction

  // Issue one divide, wait for ready, compare against the scoreboard, then retire.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp);
    int lat;
    bit stall_ok;
    exp_q.push_back(exp);
    lat_q.push_back(model_lat(a, b, s));
    @(posedge clk); #1;
    start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
    lat = 0;
    stall_ok = 1'b1;
    while (lat <= 100) begin
      @(negedge clk);
      if (ready) break;
      if (!stallreq) stall_ok = 1'b0;
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(lat_q.pop_front()));
    check({tag, ".result"}, result, exp_q.pop_front());
    check({tag, ".stall_hold"}, 64'(stall_ok), 64'd1);
    check({tag, ".stall_drop"}, 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".retire"}, {result, 1'b0, ready, busy}, 67'd0);
  endtask

  initial begin
    int quiet;
    logic [31:0] ra, rb;
    logic rs;

    // Reset state
    #12;
    @(negedge clk);
    check("reset.outputs", {result, ready, busy, stallreq}, 67'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Reset in the middle of a signed divide
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b1; opdata1 = 32'hFFFF_FF9C; opdata2 = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    check("midreset.busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("midreset.outputs", {result, ready, busy}, 66'd0);
    start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    run_div("divu_7_2", 32'd7, 32'd2, 1'b0, {32'd1, 32'd3});

    // Directed vectors with hand-computed results
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    run_div("div_m7_2",   32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_7_m2",   32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD});
    run_div("div_by_zero", 32'd5, 32'd0, 1'b1, 64'd0);
    run_div("div_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});
    run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF});

    // Annul five cycles into an operation; start stays high in the annul cycle
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd7;
    repeat (5) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    check("annul.stallreq_masked", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    check("annul.busy", 64'(busy), 64'd0);
    quiet = 1;
    repeat (40) begin
      @(negedge clk);
      if (ready || busy) quiet = 0;
    end
    check("annul.no_ready", 64'(quiet), 64'd1);
    run_div("divu_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

    // Small-dividend cases (early-out path when enabled)
    run_div("divu_3_10", 32'd3, 32'd10, 1'b0, {32'd3, 32'd0});
    run_div("div_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, {32'hFFFF_FFFD, 32'd0});

    // Model-checked random operands
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'd0) rb = 32'd13;
      rs = i[0];
      run_div($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer for the DIV/DIVU radix-2 restoring divider in the EX stage.
- Latches the operands when EX issues a divide and runs one quotient bit per cycle.
- Holds the pipeline through the stall-request path until it delivers {hi,lo}.
- The pipeline stall controller consumes `stallreq`; EX forwards `annul` from flush.

Parameters:
- WIDTH, 32, operand width; counter width is clog2(WIDTH), iteration count is WIDTH.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low (asserted when 0).
- `start`  in  1  EX holds a DIV/DIVU; held high by EX until `ready` is seen.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU.
- `opdata1`  in  WIDTH  dividend (rs).
- `opdata2`  in  WIDTH  divisor (rt).
- `annul`  in  1  abort the current operation (exception/flush).
- `result`  out  2*WIDTH  {remainder(hi), quotient(lo)}.
- `ready`  out  1  `result` valid this cycle.
- `stallreq`  out  1  request pipeline hold.
- `busy`  out  1  FSM not IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; cnt=0; `result`=0; `ready`=0; `busy`=0; operand/shift registers cleared.
- States: IDLE, BYZERO, ON, END; 2-bit registered state.
- IDLE:
  - `start`=1 & `annul`=0 & `opdata2`==0 -> BYZERO.
  - `start`=1 & `annul`=0 otherwise -> ON.
  - On entry to BYZERO or ON, latch `signed_div`, the sign bits and the operand magnitudes:
    - magnitude is two's-complement negation if `signed_div` and MSB set;
    - -2^(WIDTH-1) stays 0x8000_0000 as an unsigned magnitude.
  - Set the partial-remainder/quotient register = {WIDTH'b0, |dividend|}; cnt=0.
- ON: one restoring step per cycle.
  - Shift left by 1.
  - Trial-subtract |divisor| from the upper WIDTH+1 bits.
  - If non-negative, keep the difference and set the quotient LSB to 1; else restore and set 0.
  - cnt increments; after the step with cnt==WIDTH-1 -> END.
  - Later changes to `opdata1`/`opdata2` are ignored.
- BYZERO: one cycle, next END with quotient=0, remainder=0. Decided value; no trap.
- END:
  - `ready`=1 and `result` registered.
  - Sign fix-up for signed operations:
    - quotient negated if sign1^sign2;
    - remainder negated if sign1.
  - Stay in END while `start`=1; `start`=0 -> IDLE with `ready`=0, `result` cleared to 0.
- Latency, start first seen high in IDLE at cycle T:
  - ON occupies T+1..T+WIDTH; END/`ready` at T+WIDTH+1 (T+33 for WIDTH=32).
  - Divide-by-zero path: BYZERO at T+1, END at T+2.
- `stallreq` = `start` & ~`ready` & ~`annul` (combinational). The pipeline freezes EX and older stages while it is high, which keeps `start` and the operands stable.
- `busy` = (state != IDLE).
- `annul`=1 in any state: next state IDLE, cnt=0, `ready`=0; an in-flight result is discarded.
- `annul` has priority over `start` in the same cycle.
- Back-to-back DIVs: an END->IDLE transition requires one cycle with `start`=0. The pipeline advances on `ready`, so the next DIV's `start` is first seen in IDLE, giving a minimum gap of 1 cycle.
- Overflow case (-2^31 / -1, signed): quotient=0x8000_0000, remainder=0, i.e. natural wrap; no exception.

Optional Feature:
- Macro: `DIV_EARLY_OUT_EN`.
- With it defined, in IDLE a non-zero divisor with |dividend| < |divisor| goes to END directly at T+1:
  - quotient=0, remainder=original `opdata1` (sign preserved);
  - ON is skipped and `stallreq` lasts 1 cycle.
- Without it, every non-zero divisor takes the full WIDTH iterations.

Test Plan:
- Reset mid-operation: `rst`=0 at T+10 of a DIV -> state IDLE, `ready`=0, `result`=0 immediately; a new DIVU 7/2 afterwards completes correctly.
- DIVU 100 / 7 -> `ready` exactly at T+33, `result`={32'd2, 32'd14}; `stallreq` high T..T+32, low at T+33.
- DIV -7 / 2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIV 7 / -2 -> lo=-3, hi=1.
- DIV x / 0 -> `ready` at T+2, `result`=0; DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- `annul` asserted at T+5 -> next cycle IDLE, `busy`=0, `ready` never pulses; a following DIVU 9/3 -> {0,3} at T'+33.
- With `DIV_EARLY_OUT_EN`, DIVU 3/10 -> `ready` at T+1, {32'd3, 32'd0}; without the macro -> same value at T+33.
